rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/bexkat_pkg.sv | 24 ++
 rtl/if_wb.sv | 14 +
 rtl/rom_loader.sv | 250 +++++++++++++++++++++++++
 tb/tb_rom_loader.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bexkat_pkg.sv
// Shared definitions for the bexkat SoC: loader FSM states, byte-lane count and
// big-endian lane helpers.
package bexkat_pkg;

    localparam int unsigned LANES = 4;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StWrite,
        StFlush,
        StFinish
    } loader_state_e;

    // Byte address 0 within a word maps to the most significant lane.
    function automatic logic [LANES-1:0] lane_sel(input logic [1:0] lane);
        return 4'b1000 >> lane;
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] lane, input logic [7:0] b);
        return {24'h0, b} << {~lane, 3'b000};
    endfunction

endpackage

// File: rtl/if_wb.sv
// 32-bit wishbone bus bundle, write-capable master view plus matching slave view.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_m;
    logic        ack;
    logic        stall;

    modport master (output cyc, stb, we, adr, sel, dat_m, input ack, stall);
    modport slave  (input cyc, stb, we, adr, sel, dat_m, output ack, stall);
endinterface

// File: rtl/rom_loader.sv
// Packs hps_io download bytes into big-endian 32-bit words and writes them over
// wishbone, holding the CPU in reset until the load has been flushed.
module rom_loader
    import bexkat_pkg::*;
#(
    parameter logic [7:0]  INDEX   = 8'd1,
    parameter logic [31:0] BASE    = 32'h0,
    parameter int unsigned IOAW    = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ioctl_download,
    input  logic [7:0]      ioctl_index,
    input  logic            ioctl_wr,
    input  logic [IOAW-1:0] ioctl_addr,
    input  logic [7:0]      ioctl_dout,
    output logic            ioctl_wait,
    if_wb.master            bus,
    output logic            cpu_hold,
    output logic            done,
    output logic            error
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    loader_state_e    state_q, state_d;
    logic             cyc_q, cyc_d;
    logic             stb_q, stb_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic [LANES-1:0] sel_q, sel_d;
    logic             error_q, error_d;
    logic             end_q, end_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             pend_q, pend_d;
    logic [31:0]      pend_adr_q, pend_adr_d;
    logic [1:0]       pend_lane_q, pend_lane_d;
    logic [7:0]       pend_byte_q, pend_byte_d;

    logic        accept;
    logic        flush_force;
    logic        end_now;
    logic        bus_done;
    logic [1:0]  in_lane;
    logic [31:0] addr_ext;
    logic [31:0] in_adr;
    logic        src_valid;
    logic [31:0] src_adr;
    logic [1:0]  src_lane;
    logic [7:0]  src_byte;

    assign accept   = ioctl_download && (ioctl_index == INDEX) && ioctl_wr;
    assign in_lane  = ioctl_addr[1:0];
    assign addr_ext = 32'(ioctl_addr);
    assign in_adr   = BASE + (addr_ext & ~32'h3);
    assign end_now  = end_q || !ioctl_download;
    assign bus_done = cyc_q && (bus.ack || (tmo_q == TW'(TIMEOUT - 1)));

    // Byte to merge once the current bus write retires: one parked earlier, or
    // one arriving in the very cycle the write completes.
    always_comb begin
        if (pend_q) begin
            src_valid = 1'b1;
            src_adr   = pend_adr_q;
            src_lane  = pend_lane_q;
            src_byte  = pend_byte_q;
        end else begin
            src_valid = accept && (state_q == StWrite);
            src_adr   = in_adr;
            src_lane  = in_lane;
            src_byte  = ioctl_dout;
        end
    end

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        error_d     = error_q;
        end_d       = 1'b0;
        tmo_d       = tmo_q;
        pend_d      = pend_q;
        pend_adr_d  = pend_adr_q;
        pend_lane_d = pend_lane_q;
        pend_byte_d = pend_byte_q;
        flush_force = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ioctl_download && (ioctl_index == INDEX)) begin
                    state_d = StCollect;
                    error_d = 1'b0;
                    sel_d   = '0;
                    dat_d   = '0;
                    pend_d  = 1'b0;
                    if (ioctl_wr) begin
                        adr_d = in_adr;
                        sel_d = lane_sel(in_lane);
                        dat_d = lane_data(in_lane, ioctl_dout);
                        if (in_lane == 2'd3) begin
                            state_d = StWrite;
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                            tmo_d   = '0;
                        end
                    end
                end
            end

            StCollect: begin
                if (!ioctl_download) begin
                    if (sel_q != '0) begin
                        state_d = StFlush;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        tmo_d   = '0;
                    end else begin
                        state_d = StFinish;
                    end
                end else if (accept) begin
                    if ((sel_q != '0) && (in_adr != adr_q)) begin
                        // New word: write the held one, park this byte until it retires.
                        flush_force = 1'b1;
                        pend_d      = 1'b1;
                        pend_adr_d  = in_adr;
                        pend_lane_d = in_lane;
                        pend_byte_d = ioctl_dout;
                        state_d     = StWrite;
                        cyc_d       = 1'b1;
                        stb_d       = 1'b1;
                        tmo_d       = '0;
                    end else begin
                        adr_d = in_adr;
                        sel_d = sel_q | lane_sel(in_lane);
                        dat_d = (dat_q & ~lane_data(in_lane, 8'hFF))
                              | lane_data(in_lane, ioctl_dout);
                        if (in_lane == 2'd3) begin
                            state_d = StWrite;
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                            tmo_d   = '0;
                        end
                    end
                end
            end

            StWrite, StFlush: begin
                end_d = end_now;
                if ((state_q == StWrite) && accept && !pend_q) begin
                    pend_d      = 1'b1;
                    pend_adr_d  = in_adr;
                    pend_lane_d = in_lane;
                    pend_byte_d = ioctl_dout;
                end
                if (stb_q && !bus.stall) begin
                    stb_d = 1'b0;
                end
                if (bus_done) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    sel_d = '0;
                    dat_d = '0;
                    tmo_d = '0;
                    if (!bus.ack) begin
                        error_d = 1'b1;
                    end
                    if (state_q == StFlush) begin
                        state_d = StFinish;
                    end else if (src_valid) begin
                        pend_d = 1'b0;
                        adr_d  = src_adr;
                        sel_d  = lane_sel(src_lane);
                        dat_d  = lane_data(src_lane, src_byte);
                        if (src_lane == 2'd3) begin
                            state_d = StWrite;
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                        end else if (end_now) begin
                            state_d = StFlush;
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                        end else begin
                            state_d = StCollect;
                        end
                    end else begin
                        state_d = end_now ? StFinish : StCollect;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            StFinish: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            error_q     <= 1'b0;
            end_q       <= 1'b0;
            tmo_q       <= '0;
            pend_q      <= 1'b0;
            pend_adr_q  <= '0;
            pend_lane_q <= '0;
            pend_byte_q <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            error_q     <= error_d;
            end_q       <= end_d;
            tmo_q       <= tmo_d;
            pend_q      <= pend_d;
            pend_adr_q  <= pend_adr_d;
            pend_lane_q <= pend_lane_d;
            pend_byte_q <= pend_byte_d;
        end
    end

    assign bus.cyc    = cyc_q;
    assign bus.stb    = stb_q;
    assign bus.we     = cyc_q;
    assign bus.adr    = adr_q;
    assign bus.sel    = sel_q;
    assign bus.dat_m  = dat_q;
    assign ioctl_wait = (state_q == StWrite) || (state_q == StFlush) || flush_force;
    assign cpu_hold   = (state_q == StCollect) || (state_q == StWrite) || (state_q == StFlush);
    assign done       = (state_q == StFinish);
    assign error      = error_q;

endmodule

// File: tb/tb_rom_loader.sv
// Random and directed ROM loads against a wishbone slave model; expected bus
// writes come from a byte-stream packing model and are checked by a bus monitor.
module tb_rom_loader;

    localparam logic [7:0]  IDX  = 8'd1;
    localparam logic [31:0] BASE = 32'h0;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [15:0] ioctl_addr = 16'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        ioctl_wait;
    logic        cpu_hold;
    logic        done;
    logic        error;

    if_wb wb ();

    rom_loader #(
        .INDEX   (IDX),
        .BASE    (BASE),
        .IOAW    (16),
        .TIMEOUT (255)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .bus            (wb),
        .cpu_hold       (cpu_hold),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_miss = 0;
    wr_t         exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Slave: stalls the first sl_stall cycles of each access, acks at cycle sl_ack.
    int unsigned sl_stall = 0;
    int unsigned sl_ack = 1;
    logic        sl_noack = 1'b0;
    int unsigned sl_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sl_cnt <= 0;
        else if (!wb.cyc || wb.ack) sl_cnt <= 0;
        else sl_cnt <= sl_cnt + 1;
    end

    assign wb.stall = wb.cyc && wb.stb && (sl_cnt < sl_stall);
    assign wb.ack   = wb.cyc && !sl_noack && (sl_cnt == sl_ack);

    int unsigned done_cnt = 0;
    int unsigned cyc_run = 0;
    int unsigned last_cyc_len = 0;
    int unsigned cyc_rises = 0;
    logic        cyc_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done) done_cnt++;
                if (wb.cyc) begin
                    check("wait_during_write", 32'(ioctl_wait), 32'd1);
                    cyc_run++;
                    if (!cyc_prev) cyc_rises++;
                    if (wb.ack) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_write", 32'(exp_q.size()), 32'd1);
                        end else begin
                            wr_t e;
                            e = exp_q.pop_front();
                            check("wr_adr", wb.adr, e.adr);
                            check("wr_dat", wb.dat_m, e.dat);
                            check("wr_sel", 32'(wb.sel), 32'(e.sel));
                            check("wr_we", 32'(wb.we), 32'd1);
                        end
                    end
                end else if (cyc_run != 0) begin
                    last_cyc_len = cyc_run;
                    cyc_run = 0;
                end
                cyc_prev = wb.cyc;
            end else begin
                cyc_prev = 1'b0;
                cyc_run = 0;
            end
        end
    end

    task automatic push_exp(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wr_t e;
        e.adr = adr;
        e.dat = dat;
        e.sel = sel;
        exp_q.push_back(e);
    endtask

    // Reference: bytes accumulate into a word; a word is written when its last
    // byte lane arrives, when a byte for another word arrives, or at end of load.
    task automatic model_load(input logic [15:0] a_q[$], input logic [7:0] d_q[$]);
        logic [31:0] cur = 0;
        logic [31:0] dat = 0;
        logic [3:0]  sel = 0;
        bit          have = 0;
        for (int i = 0; i < a_q.size(); i++) begin
            logic [31:0] word;
            int          lane;
            word = BASE + {16'h0, a_q[i][15:2], 2'b00};
            lane = int'(a_q[i][1:0]);
            if (have && word != cur) begin
                push_exp(cur, dat, sel);
                have = 0; dat = 0; sel = 0;
            end
            cur = word;
            have = 1;
            sel[3 - lane] = 1'b1;
            dat[8 * (3 - lane) +: 8] = d_q[i];
            if (lane == 3) begin
                push_exp(cur, dat, sel);
                have = 0; dat = 0; sel = 0;
            end
        end
        if (have) push_exp(cur, dat, sel);
    endtask

    task automatic send_byte(input logic [15:0] a, input logic [7:0] d);
        int unsigned g = 0;
        while (ioctl_wait && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 1000) check("wait_release", 32'(ioctl_wait), 32'd0);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
    endtask

    task automatic start_load(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        @(negedge clk);
        check("cpu_hold_start", 32'(cpu_hold), 32'(idx == IDX));
        if (idx == IDX) check("error_cleared", 32'(error), 32'd0);
    endtask

    task automatic end_load(input logic exp_err);
        int unsigned d0 = done_cnt;
        int unsigned g = 0;
        ioctl_download = 1'b0;
        while (done_cnt == d0 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        check("done_pulses", done_cnt - d0, 32'd1);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("error_flag", 32'(error), 32'(exp_err));
        check("cpu_hold_end", 32'(cpu_hold), 32'd0);
        exp_q.delete();
    endtask

    task automatic drive_load(input logic [15:0] a_q[$], input logic [7:0] d_q[$], input bit gaps);
        start_load(IDX);
        for (int i = 0; i < a_q.size(); i++) begin
            send_byte(a_q[i], d_q[i]);
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        end_load(1'b0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a_q[$];
        logic [7:0]  d_q[$];
        int unsigned rises0;
        int unsigned done0;
        int unsigned g;

        repeat (3) @(negedge clk);
        #1;
        check("rst_cyc", 32'(wb.cyc), 32'd0);
        check("rst_stb", 32'(wb.stb), 32'd0);
        check("rst_adr", wb.adr, 32'd0);
        check("rst_dat", wb.dat_m, 32'd0);
        check("rst_sel", 32'(wb.sel), 32'd0);
        check("rst_outs", {28'd0, ioctl_wait, cpu_hold, done, error}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Eight sequential bytes, plus minimum-latency check on the first word.
        push_exp(32'h0, 32'h00010203, 4'hF);
        push_exp(32'h4, 32'h04050607, 4'hF);
        start_load(IDX);
        for (int i = 0; i < 4; i++) send_byte(16'(i), 8'(i));
        check("lat_stb", 32'(wb.cyc && wb.stb), 32'd1);
        @(negedge clk);
        check("lat_wait_hi", 32'(ioctl_wait), 32'd1);
        @(negedge clk);
        check("lat_wait_lo", 32'(ioctl_wait), 32'd0);
        for (int i = 4; i < 8; i++) send_byte(16'(i), 8'(i));
        end_load(1'b0);

        // Five bytes: full word then partial flush.
        push_exp(32'h0, 32'hAABBCCDD, 4'hF);
        push_exp(32'h4, 32'hEE000000, 4'b1000);
        a_q = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4};
        d_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        drive_load(a_q, d_q, 1'b0);

        // Word change forces a partial write before the new byte lands.
        push_exp(32'h0, 32'h11220000, 4'b1100);
        push_exp(32'h8, 32'h33000000, 4'b1000);
        a_q = '{16'd0, 16'd1, 16'd8};
        d_q = '{8'h11, 8'h22, 8'h33};
        drive_load(a_q, d_q, 1'b0);

        // Stalling, slow slave.
        sl_stall = 3;
        sl_ack   = 5;
        a_q.delete();
        d_q.delete();
        for (int i = 0; i < 8; i++) begin
            a_q.push_back(16'(16'h100 + i));
            d_q.push_back(8'($urandom));
        end
        model_load(a_q, d_q);
        drive_load(a_q, d_q, 1'b0);

        // Slave never acks: timeout, sticky error, load still completes.
        sl_stall = 0;
        sl_ack   = 1;
        sl_noack = 1'b1;
        start_load(IDX);
        for (int i = 0; i < 4; i++) send_byte(16'(i), 8'(i));
        g = 0;
        while (wb.cyc && g < 1000) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        check("timeout_len", last_cyc_len, 32'd255);
        check("timeout_error", 32'(error), 32'd1);
        end_load(1'b1);
        sl_noack = 1'b0;

        // Random loads with random slave timing.
        for (int l = 0; l < 30; l++) begin
            logic [15:0] a;
            int unsigned n;
            sl_stall = $urandom_range(0, 2);
            sl_ack   = sl_stall + $urandom_range(1, 3);
            a_q.delete();
            d_q.delete();
            n = $urandom_range(1, 12);
            a = 16'($urandom);
            for (int i = 0; i < int'(n); i++) begin
                int unsigned r;
                a_q.push_back(a);
                d_q.push_back(8'($urandom));
                r = $urandom_range(0, 99);
                if (r < 12) a = 16'($urandom);
                else if (r >= 20) a = a + 16'd1;
            end
            model_load(a_q, d_q);
            drive_load(a_q, d_q, 1'b1);
        end
        sl_stall = 0;
        sl_ack   = 1;

        // Reset in the middle of a write abandons it.
        sl_ack = 40;
        start_load(IDX);
        for (int i = 0; i < 4; i++) send_byte(16'(i), 8'(8'h50 + i));
        check("rst_mid_pre_cyc", 32'(wb.cyc), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_cyc", 32'(wb.cyc), 32'd0);
        check("rst_mid_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_mid_wait", 32'(ioctl_wait), 32'd0);
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sl_ack = 1;
        rises0 = cyc_rises;
        done0  = done_cnt;
        repeat (30) @(negedge clk);
        check("rst_no_retry", cyc_rises - rises0, 32'd0);
        check("rst_no_done", done_cnt - done0, 32'd0);

        // Download to another slot is ignored.
        rises0 = cyc_rises;
        done0  = done_cnt;
        start_load(8'd0);
        for (int i = 0; i < 6; i++) send_byte(16'(i), 8'(i));
        ioctl_download = 1'b0;
        repeat (20) @(negedge clk);
        check("other_slot_bus", cyc_rises - rises0, 32'd0);
        check("other_slot_done", done_cnt - done0, 32'd0);
        check("other_slot_hold", 32'(cpu_hold), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
